pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WORD, default 32, datapath and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter FLUSH_CYCLES, default 2, number of cycles flush_pipeline_o is held per redirect (legal range 1..7).
REQ-004 clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 stall_i  input  1  hazard stall; while high the PC is not advanced.
REQ-007 fetch_ready_i  input  1  instruction memory accepts pc_o this cycle.
REQ-008 take_branch_i  input  1  one-cycle branch request from the execute-stage branch logic.
REQ-009 branch_exch_i  input  1  request is a register branch (BX/BLX/MOV PC/ADD PC); qualifies the Thumb-bit check.
REQ-010 branch_target_i  input  WORD  branch destination, sampled when take_branch_i is high.
REQ-011 pc_o  output  WORD  current fetch address.
REQ-012 pc_valid_o  output  1  pc_o is a legal address to fetch.
REQ-013 flush_pipeline_o  output  1  kill fetch/decode contents.
REQ-014 state_fault_o  output  1  sticky; set when an exchange branch targets ARM state.

Function
REQ-015 The FSM SHALL have three states: RUN, PENDING, and FLUSH.
REQ-016 In RUN, when fetch_ready_i=1, stall_i=0, and take_branch_i=0, pc_o SHALL advance by 2 (modulo 2^WORD; 0xFFFF_FFFE wraps to 0x0).
REQ-017 In RUN, when fetch_ready_i=0 or stall_i=1, pc_o SHALL hold.
REQ-018 take_branch_i=1 in any state SHALL capture {branch_target_i[WORD-1:1],1'b0} into the pending-target register, discarding any older pending target.
REQ-019 The cycle after take_branch_i=1, flush_pipeline_o SHALL be 1 and the flush counter SHALL load FLUSH_CYCLES.
REQ-020 On the branch cycle, if stall_i=0 and fetch_ready_i=1, the next pc_o SHALL be the captured target and the next state SHALL be FLUSH; otherwise the next state SHALL be PENDING.
REQ-021 In PENDING, pc_valid_o SHALL be 0 and pc_o SHALL hold.
REQ-022 PENDING SHALL go to FLUSH on the first cycle with stall_i=0 and fetch_ready_i=1, loading pc_o with the pending target on the same edge.
REQ-023 flush_pipeline_o SHALL remain 1 while the counter is nonzero.
REQ-024 The counter SHALL decrement once per cycle in both PENDING and FLUSH; if it reaches 0 while in PENDING, flush SHALL stay 1 until pc_o is loaded.
REQ-025 In FLUSH, pc_o SHALL advance by 2 on fetch_ready_i=1 and stall_i=0.
REQ-026 FLUSH SHALL return to RUN when the counter reaches 0, with flush_pipeline_o deasserting on that edge.
REQ-027 A take_branch_i=1 during PENDING or FLUSH SHALL restart the sequence per REQ-018 to REQ-020, reloading the counter; the newest target wins.
REQ-028 A take_branch_i=1 arriving while flush_pipeline_o=1 SHALL be honoured.
REQ-029 When branch_exch_i=1 and branch_target_i[0]=0 on a taken branch, state_fault_o SHALL set and hold until reset; the redirect SHALL still occur.
REQ-030 pc_valid_o SHALL be 1 in RUN and FLUSH, and 0 in PENDING and during reset.
REQ-031 pc_o bit 0 SHALL always be 0.

Reset
REQ-032 Asserting reset_n_i=0 SHALL immediately force: state RUN, pc_o=RESET_PC, pc_valid_o=0, flush_pipeline_o=0, counter=0, pending target=0, state_fault_o=0.
REQ-033 pc_valid_o SHALL rise on the first clock edge after reset_n_i deasserts.
REQ-034 Reset mid-PENDING or mid-FLUSH SHALL discard the pending target.

Verification
REQ-035 Reset release, fetch_ready_i=1 for 4 cycles -> pc_o steps 0x0, 0x2, 0x4, 0x6, 0x8; flush stays 0.
REQ-036 take_branch_i with target 0x100 and no stall -> next cycle pc_o=0x100 and flush=1 for exactly 2 cycles, then pc_o=0x102, 0x104.
REQ-037 take_branch_i with target 0x200 while stall_i=1 for 3 cycles -> PENDING, pc_valid_o=0, flush=1 throughout; pc_o=0x200 on the edge after stall drops.
REQ-038 Branch to 0x300, then branch to 0x400 one cycle later -> pc_o lands on 0x400 and flush is held 2 cycles from the second branch.
REQ-039 branch_exch_i=1 with target 0x501 -> pc_o=0x500 and state_fault_o=0; with target 0x500 -> state_fault_o=1 and sticky.
REQ-040 PC at 0xFFFF_FFFE advancing -> pc_o=0x0; reset_n_i pulled low mid-FLUSH -> outputs take reset values asynchronously.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: Thumb fetch-PC sequencer with branch redirect, stall-pending hold and timed pipeline flush
module pc_sequencer #(
  parameter int WORD = 32,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  input  logic            take_branch_i,
  input  logic            branch_exch_i,
  input  logic [WORD-1:0] branch_target_i,
  output logic [WORD-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            flush_pipeline_o,
  output logic            state_fault_o
);
  localparam logic [1:0] RUN = 2'd0, PENDING = 2'd1, FLUSH = 2'd2;
  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
  localparam logic [WORD-2:0] ONE = {{(WORD-2){1'b0}}, 1'b1};
  // PC and pending target are kept as halfword addresses so bit 0 is structurally zero
  logic [1:0] state, state_n;
  logic [WORD-2:0] pc_q, pc_n, pend_q, pend_n;
  logic [2:0] cnt, cnt_n, cnt_dec;
  logic live, adv;
  assign adv = fetch_ready_i & ~stall_i;
  assign cnt_dec = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
  always_comb begin
    state_n = state;
    pc_n = pc_q;
    pend_n = pend_q;
    cnt_n = cnt;
    if (take_branch_i) begin
      pend_n = branch_target_i[WORD-1:1];
      cnt_n = FC;
      state_n = adv ? FLUSH : PENDING;
      pc_n = adv ? branch_target_i[WORD-1:1] : pc_q;
    end else if (state == RUN) begin
      pc_n = adv ? pc_q + ONE : pc_q;
    end else if (state == PENDING) begin
      cnt_n = cnt_dec;
      state_n = adv ? FLUSH : PENDING;
      pc_n = adv ? pend_q : pc_q;
    end else begin
      cnt_n = cnt_dec;
      state_n = (cnt_dec == 3'd0) ? RUN : FLUSH;
      pc_n = adv ? pc_q + ONE : pc_q;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= RUN;
      pc_q <= RESET_PC[WORD-1:1];
      pend_q <= '0;
      cnt <= '0;
      live <= 1'b0;
      state_fault_o <= 1'b0;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      pend_q <= pend_n;
      cnt <= cnt_n;
      live <= 1'b1;
      state_fault_o <= state_fault_o | (take_branch_i & branch_exch_i & ~branch_target_i[0]);
    end
  end
  // Flush spans every non-RUN cycle, so an exhausted counter in PENDING still keeps it high
  assign pc_o = {pc_q, 1'b0};
  assign pc_valid_o = live & (state != PENDING);
  assign flush_pipeline_o = state != RUN;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer with directed scenarios and a random tail
module tb_pc_sequencer;
  logic clk_i = 1'b0;
  logic reset_n_i, stall_i, fetch_ready_i, take_branch_i, branch_exch_i;
  logic [31:0] branch_target_i, pc_o;
  logic pc_valid_o, flush_pipeline_o, state_fault_o;
  int total = 0, bad = 0;
  logic [34:0] sb[$];
  logic [31:0] m_pc, m_tgt;
  int m_mode, m_cnt;
  logic m_fault, m_live;
  pc_sequencer #(.WORD(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
    .take_branch_i(take_branch_i), .branch_exch_i(branch_exch_i), .branch_target_i(branch_target_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_pipeline_o(flush_pipeline_o), .state_fault_o(state_fault_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [34:0] m_out();
    return {m_pc, m_live && m_mode != 1, m_mode != 0, m_fault};
  endfunction
  task automatic m_reset();
    m_pc = 32'h0; m_tgt = 32'h0; m_mode = 0; m_cnt = 0; m_fault = 1'b0; m_live = 1'b0;
  endtask
  // reference: mode 0=RUN 1=PENDING 2=FLUSH, m_cnt = flush cycles left
  task automatic m_step();
    bit go = fetch_ready_i && !stall_i;
    m_live = 1'b1;
    if (take_branch_i) begin
      m_tgt = {branch_target_i[31:1], 1'b0};
      if (branch_exch_i && !branch_target_i[0]) m_fault = 1'b1;
      m_cnt = 2;
      m_mode = go ? 2 : 1;
      if (go) m_pc = m_tgt;
    end else if (m_mode == 0) begin
      if (go) m_pc = m_pc + 32'd2;
    end else begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (m_mode == 1) begin
        if (go) begin m_pc = m_tgt; m_mode = 2; end
      end else begin
        if (go) m_pc = m_pc + 32'd2;
        if (m_cnt == 0) m_mode = 0;
      end
    end
  endtask
  task automatic cyc(input logic stl, input logic rdy, input logic br, input logic exch, input logic [31:0] tgt);
    logic [34:0] e;
    stall_i = stl; fetch_ready_i = rdy; take_branch_i = br; branch_exch_i = exch; branch_target_i = tgt;
    m_step();
    sb.push_back(m_out());
    @(posedge clk_i); #1;
    e = sb.pop_front();
    chk("sb", {29'd0, pc_o, pc_valid_o, flush_pipeline_o, state_fault_o}, {29'd0, e});
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, {32'd0, pc_o}, 64'h0);
    chk({tag, "_valid"}, {63'd0, pc_valid_o}, 64'd0);
    chk({tag, "_flush"}, {63'd0, flush_pipeline_o}, 64'd0);
    chk({tag, "_fault"}, {63'd0, state_fault_o}, 64'd0);
  endtask
  initial begin
    reset_n_i = 1'b0; stall_i = 1'b0; fetch_ready_i = 1'b0; take_branch_i = 1'b0;
    branch_exch_i = 1'b0; branch_target_i = 32'h0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1 chk_reset("rst");
    reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    chk("run_pc8", {32'd0, pc_o}, 64'h8);
    chk("run_noflush", {63'd0, flush_pipeline_o}, 64'd0);
    chk("run_valid", {63'd0, pc_valid_o}, 64'd1);
    cyc(0, 1, 1, 0, 32'h100);
    chk("br_pc", {32'd0, pc_o}, 64'h100);
    chk("br_flush", {63'd0, flush_pipeline_o}, 64'd1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("br_after", {32'd0, pc_o}, 64'h104);
    chk("br_flush_end", {63'd0, flush_pipeline_o}, 64'd0);
    cyc(1, 1, 1, 0, 32'h200);
    chk("pend_valid", {63'd0, pc_valid_o}, 64'd0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("pend_flush", {63'd0, flush_pipeline_o}, 64'd1);
    chk("pend_hold", {32'd0, pc_o}, 64'h104);
    cyc(0, 1, 0, 0, 0);
    chk("pend_load", {32'd0, pc_o}, 64'h200);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 32'h300);
    cyc(0, 1, 1, 0, 32'h400);
    chk("rebr_pc", {32'd0, pc_o}, 64'h400);
    cyc(0, 1, 0, 0, 0);
    chk("rebr_flush", {63'd0, flush_pipeline_o}, 64'd1);
    cyc(0, 1, 0, 0, 0);
    chk("rebr_done", {63'd0, flush_pipeline_o}, 64'd0);
    cyc(1, 1, 1, 0, 32'h700);
    cyc(0, 0, 1, 0, 32'h800);
    cyc(0, 1, 0, 0, 0);
    chk("pend_newest", {32'd0, pc_o}, 64'h800);
    cyc(0, 1, 1, 1, 32'h501);
    chk("exch_pc", {32'd0, pc_o}, 64'h500);
    chk("exch_nofault", {63'd0, state_fault_o}, 64'd0);
    cyc(0, 1, 1, 1, 32'h500);
    chk("exch_fault", {63'd0, state_fault_o}, 64'd1);
    repeat (3) cyc(0, 1, 0, 0, 0);
    chk("fault_sticky", {63'd0, state_fault_o}, 64'd1);
    cyc(0, 1, 1, 0, 32'hFFFF_FFFE);
    cyc(0, 1, 0, 0, 0);
    chk("wrap", {32'd0, pc_o}, 64'h0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 32'h600);
    #2 reset_n_i = 1'b0;
    #1 chk_reset("async_rst");
    m_reset();
    @(posedge clk_i); #1;
    chk_reset("rst_hold");
    reset_n_i = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("rst_release_valid", {63'd0, pc_valid_o}, 64'd1);
    chk("rst_release_pc", {32'd0, pc_o}, 64'h2);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1, $urandom | ($urandom_range(0, 7) != 0 ? 32'h1 : 32'h0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
